// File: rtl/rwmem_be_clr.sv
// Single-port scratchpad: byte-lane writes, registered read with valid strobe,
// selectable read-during-write policy and a sequential zero-clear engine.
module rwmem_be_clr #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int BYTE_W     = 8,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          din,
  input  logic                       we,
  input  logic [DATA_W/BYTE_W-1:0]   be,
  input  logic                       re,
  input  logic                       clr,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid,
  output logic                       busy
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  generate
    if (DATA_W % BYTE_W != 0) begin : g_bad_width
      $error("rwmem_be_clr: DATA_W must be a multiple of BYTE_W");
    end
  endgenerate

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   cnt_reg;
  logic [DATA_W-1:0]   dout_reg;
  logic                dout_valid_reg;
  logic                busy_reg;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                clearing;
  logic                host_wr;
  logic [ADDR_W-1:0]   wr_addr;
  logic [NB-1:0]       lane_we;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   rd_old;
  logic [DATA_W-1:0]   rd_merged;
  logic [DATA_W-1:0]   rd_next;

  // clr in IDLE pre-empts any host access issued in the same cycle
  assign clearing = (state_reg == ST_CLEAR);
  assign host_wr  = (state_reg == ST_IDLE) && !clr && we;
  assign wr_addr  = clearing ? cnt_reg : addr;
  assign rd_old   = mem[addr];

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign lane_we[gi] = clearing | (host_wr & be[gi]);
    assign wr_data[gi*BYTE_W +: BYTE_W] =
      clearing ? '0 : din[gi*BYTE_W +: BYTE_W];
    assign rd_merged[gi*BYTE_W +: BYTE_W] =
      (host_wr & be[gi]) ? din[gi*BYTE_W +: BYTE_W] : rd_old[gi*BYTE_W +: BYTE_W];
  end

  // Write-first returns the word as it will look after this edge's write
  assign rd_next = (RDW_MODE != 0) ? rd_merged : rd_old;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (lane_we[i]) begin
        mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      busy_reg       <= (CLR_ON_RST != 0);
      cnt_reg        <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      dout_valid_reg <= 1'b0;
      case (state_reg)
        ST_CLEAR: begin
          if (cnt_reg == LAST_ADDR) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          if (clr) begin
            state_reg <= ST_CLEAR;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
          end else if (re) begin
            dout_reg       <= rd_next;
            dout_valid_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_rwmem_be_clr.sv
// Bench for rwmem_be_clr: read-first, write-first and no-clear-on-reset instances
// checked against a word-array reference model driven by random and directed traffic.
module tb_rwmem_be_clr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rst_n2 = 1'b1;
  logic [3:0]  addr;
  logic [15:0] din;
  logic        we, re, clr;
  logic [1:0]  be;
  logic [15:0] dout0, dout1, dout2;
  logic        dv0, dv1, dv2;
  logic        busy0, busy1, busy2;

  rwmem_be_clr #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .RDW_MODE(0), .CLR_ON_RST(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .we(we), .be(be), .re(re),
    .clr(clr), .dout(dout0), .dout_valid(dv0), .busy(busy0));

  rwmem_be_clr #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .RDW_MODE(1), .CLR_ON_RST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .we(we), .be(be), .re(re),
    .clr(clr), .dout(dout1), .dout_valid(dv1), .busy(busy1));

  rwmem_be_clr #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .RDW_MODE(0), .CLR_ON_RST(0)) dut2 (
    .clk(clk), .rst_n(rst_n2), .addr(addr), .din(din), .we(we), .be(be), .re(re),
    .clr(clr), .dout(dout2), .dout_valid(dv2), .busy(busy2));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain word array plus "clear cycles remaining"
  logic [15:0] mem_m [16];
  int          busy_left;
  logic [15:0] exp_d0, exp_d1;
  logic        exp_valid;
  logic        eb;

  task automatic model_reset();
    busy_left = 16;
    exp_d0    = 16'h0;
    exp_d1    = 16'h0;
    exp_valid = 1'b0;
    eb        = 1'b1;
  endtask

  task automatic model_edge();
    logic [15:0] old_w, new_w;
    if (busy_left > 0) begin
      mem_m[16 - busy_left] = 16'h0;
      busy_left--;
      exp_valid = 1'b0;
    end else if (clr) begin
      busy_left = 16;
      exp_valid = 1'b0;
    end else begin
      old_w = mem_m[addr];
      new_w = old_w;
      if (be[0]) new_w[7:0]  = din[7:0];
      if (be[1]) new_w[15:8] = din[15:8];
      if (re) begin
        exp_d0    = old_w;
        exp_d1    = we ? new_w : old_w;
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      if (we) mem_m[addr] = new_w;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    eb = (busy_left != 0);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; re = 1'b0; clr = 1'b0; be = 2'b00; addr = 4'h0; din = 16'h0;
  endtask

  task automatic rand_inputs(input bit allow_clr);
    addr = 4'($urandom_range(0, 15));
    din  = 16'($urandom);
    be   = 2'($urandom_range(0, 3));
    we   = 1'($urandom_range(0, 1));
    re   = 1'($urandom_range(0, 1));
    clr  = allow_clr ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic test_reset();
    int cycles;
    idle_inputs();
    rst_n = 1'b0; rst_n2 = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({dout0, dout1, dv0, dv1, busy0, busy1} !== {16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got d0=%h d1=%h v=%b%b b=%b%b exp d0=0 d1=0 v=00 b=11",
               dout0, dout1, dv0, dv1, busy0, busy1);
    end
    tick(); tick();
    rst_n = 1'b1;
    cycles = 0;
    while (busy0 === 1'b1 && cycles < 40) begin
      cycles++;
      tick();
      n_tests++;
      if ({dout0, dout1, dv0, dv1, busy0, busy1} !== {exp_d0, exp_d1, exp_valid, exp_valid, eb, eb}) begin
        n_fail++;
        $display("FAIL init_clear[%0d]: got d0=%h d1=%h v=%b%b b=%b%b exp d0=%h d1=%h v=%b b=%b",
                 cycles, dout0, dout1, dv0, dv1, busy0, busy1, exp_d0, exp_d1, exp_valid, eb);
      end
    end
    n_tests++;
    if (cycles !== 16) begin
      n_fail++;
      $display("FAIL init_busy_len: got %0d cycles exp 16", cycles);
    end
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a); re = 1'b1;
      tick();
      n_tests++;
      if ({dout0, dout1, dv0, dv1} !== {16'h0, 16'h0, 1'b1, 1'b1} ||
          {dout0, dout1} !== {exp_d0, exp_d1}) begin
        n_fail++;
        $display("FAIL init_read[%0d]: got d0=%h d1=%h v=%b%b exp d0=0000 d1=0000 v=11",
                 a, dout0, dout1, dv0, dv1);
      end
    end
    re = 1'b0;
    tick();
    n_tests++;
    if ({dv0, dv1} !== 2'b00) begin
      n_fail++;
      $display("FAIL init_valid_drop: got v=%b%b exp v=00", dv0, dv1);
    end
  endtask

  task automatic test_byte_enable();
    idle_inputs();
    addr = 4'd3; we = 1'b1; din = 16'hA5C3; be = 2'b11;
    tick();
    din = 16'hFF11; be = 2'b01;
    tick();
    we = 1'b0; be = 2'b00; re = 1'b1;
    tick();
    n_tests++;
    if ({dout0, dout1, dv0, dv1} !== {16'hA511, 16'hA511, 1'b1, 1'b1} ||
        {dout0, dout1} !== {exp_d0, exp_d1}) begin
      n_fail++;
      $display("FAIL byte_enable: got d0=%h d1=%h v=%b%b exp d0=a511 d1=a511 v=11",
               dout0, dout1, dv0, dv1);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_rdw();
    idle_inputs();
    addr = 4'd5; we = 1'b1; din = 16'h1234; be = 2'b11;
    tick();
    re = 1'b1; din = 16'hBEEF;
    tick();
    n_tests++;
    if ({dout0, dout1} !== {16'h1234, 16'hBEEF} || {dout0, dout1} !== {exp_d0, exp_d1} ||
        {dv0, dv1} !== 2'b11) begin
      n_fail++;
      $display("FAIL rdw_same_cycle: got d0=%h d1=%h v=%b%b exp d0=1234 d1=beef v=11",
               dout0, dout1, dv0, dv1);
    end
    we = 1'b0; be = 2'b00;
    tick();
    n_tests++;
    if ({dout0, dout1} !== {16'hBEEF, 16'hBEEF} || {dv0, dv1} !== 2'b11) begin
      n_fail++;
      $display("FAIL rdw_readback: got d0=%h d1=%h v=%b%b exp d0=beef d1=beef v=11",
               dout0, dout1, dv0, dv1);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      rand_inputs(1'b0);
      tick();
      n_tests++;
      if ({dout0, dout1, dv0, dv1, busy0, busy1} !== {exp_d0, exp_d1, exp_valid, exp_valid, eb, eb}) begin
        n_fail++;
        $display("FAIL random[%0d]: got d0=%h d1=%h v=%b%b b=%b%b exp d0=%h d1=%h v=%b b=%b",
                 n, dout0, dout1, dv0, dv1, busy0, busy1, exp_d0, exp_d1, exp_valid, eb);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_clr();
    int cycles;
    idle_inputs();
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a); we = 1'b1; be = 2'b11; din = 16'(a * 16'h0101);
      tick();
    end
    addr = 4'd7; din = 16'hFFFF; we = 1'b1; re = 1'b1; clr = 1'b1;
    tick();
    n_tests++;
    if ({dv0, dv1, busy0, busy1} !== 4'b0011 || eb !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_start: got v=%b%b b=%b%b exp v=00 b=11", dv0, dv1, busy0, busy1);
    end
    cycles = 0;
    while (busy0 === 1'b1 && cycles < 40) begin
      cycles++;
      rand_inputs(1'b1);
      tick();
      n_tests++;
      if ({dout0, dout1, dv0, dv1, busy0, busy1} !== {exp_d0, exp_d1, exp_valid, exp_valid, eb, eb}) begin
        n_fail++;
        $display("FAIL clr_busy[%0d]: got d0=%h d1=%h v=%b%b b=%b%b exp d0=%h d1=%h v=%b b=%b",
                 cycles, dout0, dout1, dv0, dv1, busy0, busy1, exp_d0, exp_d1, exp_valid, eb);
      end
    end
    n_tests++;
    if (cycles !== 16) begin
      n_fail++;
      $display("FAIL clr_busy_len: got %0d cycles exp 16", cycles);
    end
    idle_inputs();
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a); re = 1'b1;
      tick();
      n_tests++;
      if ({dout0, dout1, dv0, dv1} !== {16'h0, 16'h0, 1'b1, 1'b1} ||
          {dout0, dout1} !== {exp_d0, exp_d1}) begin
        n_fail++;
        $display("FAIL clr_read[%0d]: got d0=%h d1=%h v=%b%b exp d0=0000 d1=0000 v=11",
                 a, dout0, dout1, dv0, dv1);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_midclear();
    int cycles;
    idle_inputs();
    addr = 4'd2; we = 1'b1; be = 2'b11; din = 16'h5A5A;
    tick();
    we = 1'b0; re = 1'b1;
    tick();
    re = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({dout0, dout1, dv0, dv1, busy0, busy1} !== {16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL midclear_reset: got d0=%h d1=%h v=%b%b b=%b%b exp d0=0 d1=0 v=00 b=11",
               dout0, dout1, dv0, dv1, busy0, busy1);
    end
    tick(); tick();
    rst_n = 1'b1;
    cycles = 0;
    while (busy0 === 1'b1 && cycles < 40) begin
      cycles++;
      tick();
      n_tests++;
      if ({dout0, dout1, dv0, dv1, busy0, busy1} !== {exp_d0, exp_d1, exp_valid, exp_valid, eb, eb}) begin
        n_fail++;
        $display("FAIL midclear_busy[%0d]: got d0=%h d1=%h v=%b%b b=%b%b exp d0=%h d1=%h v=%b b=%b",
                 cycles, dout0, dout1, dv0, dv1, busy0, busy1, exp_d0, exp_d1, exp_valid, eb);
      end
    end
    n_tests++;
    if (cycles !== 16 || {dout0, dv0} !== {16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL midclear_len: got %0d cycles d0=%h v=%b exp 16 cycles d0=0000 v=0",
               cycles, dout0, dv0);
    end
    for (int a = 0; a < 16; a += 5) begin
      addr = 4'(a); re = 1'b1;
      tick();
      n_tests++;
      if ({dout0, dout1, dv0} !== {16'h0, 16'h0, 1'b1} || {dout0, dout1} !== {exp_d0, exp_d1}) begin
        n_fail++;
        $display("FAIL midclear_read[%0d]: got d0=%h d1=%h v=%b exp d0=0000 d1=0000 v=1",
                 a, dout0, dout1, dv0);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_no_clr_on_rst();
    idle_inputs();
    n_tests++;
    if ({dout2, dv2, busy2} !== {16'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL noclr_in_reset: got d=%h v=%b b=%b exp d=0000 v=0 b=0", dout2, dv2, busy2);
    end
    rst_n2 = 1'b1;
    #1;
    n_tests++;
    if (busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL noclr_busy: got b=%b exp b=0", busy2);
    end
    addr = 4'd15; din = 16'h00FF; be = 2'b11; we = 1'b1;
    tick();
    we = 1'b0; be = 2'b00; re = 1'b1;
    tick();
    n_tests++;
    if ({dout2, dv2, busy2} !== {16'h00FF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL noclr_read: got d=%h v=%b b=%b exp d=00ff v=1 b=0", dout2, dv2, busy2);
    end
    re = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = 4'($urandom_range(0, 15));
      tick();
      n_tests++;
      if ({dout2, dv2} !== {16'h00FF, 1'b0}) begin
        n_fail++;
        $display("FAIL noclr_hold[%0d]: got d=%h v=%b exp d=00ff v=0", i, dout2, dv2);
      end
    end
  endtask

  initial begin
    idle_inputs();
    #2;
    test_reset();
    test_byte_enable();
    test_rdw();
    test_random();
    test_clr();
    test_reset_midclear();
    test_no_clr_on_rst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
